// File: rtl/prim_generic_sync_filter_pkg.sv
// Shared helpers for the synchroniser/stability-filter primitive.
package prim_generic_sync_filter_pkg;

  // Counter width able to hold 0..filter_cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/prim_generic_sync_filter_bit.sv
// One bit of the synchroniser: sync chain, stability counter, accepted level
// and registered rise/fall strobes.
module prim_generic_sync_filter_bit
  import prim_generic_sync_filter_pkg::*;
#(
  parameter int unsigned Stages       = 2,
  parameter int unsigned FilterCycles = 4,
  parameter logic        ResetValue   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic en_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CntW   = cnt_width(FilterCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic [Stages-1:0] sync_q;
  logic              s;
  logic              q_q, q_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Discrete reset flops forming the metastability chain; runs regardless of en_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {Stages{ResetValue}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign s = sync_q[Stages-1];

  // A mismatch must persist FilterCycles consecutive cycles before acceptance.
  always_comb begin
    q_d    = q_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en_i && (s != q_q)) begin
      if (cnt_q == CntMax) begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= ResetValue;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/prim_generic_sync_filter.sv
// Width-bit N-stage synchroniser with per-bit stability filter and edge strobes.
module prim_generic_sync_filter
  import prim_generic_sync_filter_pkg::*;
#(
  parameter int unsigned      Width        = 16,
  parameter int unsigned      Stages       = 2,
  parameter int unsigned      FilterCycles = 4,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  if (Stages < 2) begin : g_bad_stages
    $fatal(1, "prim_generic_sync_filter: Stages must be >= 2");
  end
  if (FilterCycles < 1) begin : g_bad_filter
    $fatal(1, "prim_generic_sync_filter: FilterCycles must be >= 1");
  end

  // Bits are fully independent; one filter instance per bit.
  for (genvar i = 0; i < int'(Width); i++) begin : g_bit
    prim_generic_sync_filter_bit #(
      .Stages      (Stages),
      .FilterCycles(FilterCycles),
      .ResetValue  (ResetValue[i])
    ) u_bit (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (d_i[i]),
      .en_i  (en_i),
      .q_o   (q_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
    );
  end

endmodule

// File: tb/tb_prim_generic_sync_filter.sv
// Directed self-checking bench for prim_generic_sync_filter (Width=2, Stages=2, FilterCycles=4).
module tb_prim_generic_sync_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] d, d_b;
  logic [1:0] q, rise, fall;
  logic [1:0] q_b, rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_generic_sync_filter #(
    .Width(2), .Stages(2), .FilterCycles(4), .ResetValue(2'b00)
  ) dut (
    .clk_i(clk), .rst_i(rst), .d_i(d), .en_i(en),
    .q_o(q), .rise_o(rise), .fall_o(fall)
  );

  prim_generic_sync_filter #(
    .Width(2), .Stages(2), .FilterCycles(4), .ResetValue(2'b10)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .d_i(d_b), .en_i(en),
    .q_o(q_b), .rise_o(rise_b), .fall_o(fall_b)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks q/rise/fall of the primary instance together.
  task automatic chk3(input string tag, input logic [1:0] eq, input logic [1:0] er,
                      input logic [1:0] ef);
    check({tag, ".q"}, q, eq);
    check({tag, ".rise"}, rise, er);
    check({tag, ".fall"}, fall, ef);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; d = 2'b11; d_b = 2'b10;
    #1 rst = 1'b1;

    // Reset hold: outputs stay at reset value while input differs.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk3("rst_hold", 2'b00, 2'b00, 2'b00);
    end
    check("rst_hold.q_b", q_b, 2'b10);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk3("rst_rel_wait", 2'b00, 2'b00, 2'b00);
    end
    tick(1);
    chk3("rst_rel_edge6", 2'b11, 2'b11, 2'b00);
    tick(1);
    chk3("rst_rel_after", 2'b11, 2'b00, 2'b00);

    // Clean rising edge on bit 0 from a fresh reset.
    rst = 1'b1; d = 2'b00;
    tick(1);
    rst = 1'b0;
    tick(2);
    d = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk3("clean_wait", 2'b00, 2'b00, 2'b00);
    end
    tick(1);
    chk3("clean_edge6", 2'b01, 2'b01, 2'b00);
    tick(1);
    chk3("clean_after", 2'b01, 2'b00, 2'b00);

    // Clean falling edge back to 00.
    d = 2'b00;
    tick(5);
    chk3("fall_wait", 2'b01, 2'b00, 2'b00);
    tick(1);
    chk3("fall_edge6", 2'b00, 2'b00, 2'b01);
    tick(1);
    chk3("fall_after", 2'b00, 2'b00, 2'b00);

    // Glitch of 3 cycles is rejected.
    d = 2'b01;
    tick(3);
    d = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk3("glitch", 2'b00, 2'b00, 2'b00);
    end

    // Enable gating: no acceptance while disabled, full count after enable.
    en = 1'b0; d = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk3("en_off", 2'b00, 2'b00, 2'b00);
    end
    en = 1'b1;
    tick(3);
    chk3("en_on_wait", 2'b00, 2'b00, 2'b00);
    tick(1);
    chk3("en_on_edge4", 2'b01, 2'b01, 2'b00);
    tick(1);
    chk3("en_on_after", 2'b01, 2'b00, 2'b00);

    // Disable mid-count discards progress.
    d = 2'b00;
    tick(4);
    en = 1'b0;
    tick(3);
    chk3("en_mid_off", 2'b01, 2'b00, 2'b00);
    en = 1'b1;
    tick(3);
    chk3("en_mid_wait", 2'b01, 2'b00, 2'b00);
    tick(1);
    chk3("en_mid_edge4", 2'b00, 2'b00, 2'b01);

    // Independent bits: 10 -> 01 gives simultaneous rise and fall.
    d_b = 2'b01;
    tick(5);
    check("indep_wait.q", q_b, 2'b10);
    check("indep_wait.rise", rise_b, 2'b00);
    tick(1);
    check("indep.q", q_b, 2'b01);
    check("indep.rise", rise_b, 2'b01);
    check("indep.fall", fall_b, 2'b10);
    tick(1);
    check("indep_after.rise", rise_b, 2'b00);
    check("indep_after.fall", fall_b, 2'b00);

    // Reset mid-count, then a full latency with no pulse at release.
    tick(2);
    d = 2'b11;
    tick(4);
    rst = 1'b1;
    #1;
    chk3("rst_mid_async", 2'b00, 2'b00, 2'b00);
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk3("rst_mid_wait", 2'b00, 2'b00, 2'b00);
    end
    tick(1);
    chk3("rst_mid_edge6", 2'b11, 2'b11, 2'b00);

    // Reset while a pulse is high clears it asynchronously.
    rst = 1'b1;
    #1;
    chk3("rst_pulse_async", 2'b00, 2'b00, 2'b00);
    check("rst_pulse_async.q_b", q_b, 2'b10);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk3("final", 2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
